// File: rtl/ram512_arbiter.sv
// Two-requester arbiter for the shared single-port 512x16 data RAM: round-robin
// between the CPU data port (A) and the refresh/DMA engine (B), with bounded lock bursts.
module ram512_arbiter #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              a_req,
    input  logic              a_we,
    input  logic              a_lock,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic              b_lock,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,

    output logic [DATA_W-1:0] ram_data,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_address,
    input  logic [DATA_W-1:0] ram_out
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_A,
        OWN_B
    } owner_e;

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);
    localparam logic [3:0] BURST_SAT   = 4'd15;

    owner_e     owner;
    logic       last_b;      // 1 when B took the most recent grant
    logic [3:0] burst_cnt;
    logic [1:0] pend_rd;     // bit 0: A read in flight, bit 1: B read in flight

    logic hold_a;
    logic hold_b;
    logic sel_a;
    logic sel_b;

    // Grant decision: lock hold first, then a lone requester, then round-robin.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        sel_a  = 1'b0;
        sel_b  = 1'b0;
        hold_a = (owner == OWN_A) && a_req && ((burst_cnt < BURST_LIMIT) || !b_req);
        hold_b = (owner == OWN_B) && b_req && ((burst_cnt < BURST_LIMIT) || !a_req);
        if (hold_a) begin
            sel_a = 1'b1;
        end else if (hold_b) begin
            sel_b = 1'b1;
        end else if (a_req && b_req) begin
            sel_a = last_b;
            sel_b = !last_b;
        end else begin
            sel_a = a_req;
            sel_b = b_req;
        end
    end

    // Grants are suppressed while reset is held so the RAM sees no load.
    assign a_gnt = sel_a & rst_n;
    assign b_gnt = sel_b & rst_n;

    always_comb begin
        ram_load    = 1'b0;
        ram_address = '0;
        ram_data    = '0;
        if (a_gnt) begin
            ram_load    = a_we;
            ram_address = a_addr;
            ram_data    = a_wdata;
        end else if (b_gnt) begin
            ram_load    = b_we;
            ram_address = b_addr;
            ram_data    = b_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= OWN_NONE;
            last_b    <= 1'b1;
            burst_cnt <= 4'd0;
            pend_rd   <= 2'b00;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            pend_rd <= {b_gnt & !b_we, a_gnt & !a_we};
            if (a_gnt) begin
                last_b    <= 1'b0;
                burst_cnt <= (owner != OWN_A)        ? 4'd1 :
                             (burst_cnt == BURST_SAT) ? BURST_SAT : burst_cnt + 4'd1;
                owner     <= a_lock ? OWN_A : OWN_NONE;
            end else if (b_gnt) begin
                last_b    <= 1'b1;
                burst_cnt <= (owner != OWN_B)        ? 4'd1 :
                             (burst_cnt == BURST_SAT) ? BURST_SAT : burst_cnt + 4'd1;
                owner     <= b_lock ? OWN_B : OWN_NONE;
            end else begin
                owner     <= OWN_NONE;
                burst_cnt <= 4'd0;
            end
        end
    end

    // The RAM output is registered, so it lines up with the read tag one cycle later.
    assign a_rvalid = pend_rd[0];
    assign b_rvalid = pend_rd[1];
    assign a_rdata  = pend_rd[0] ? ram_out : '0;
    assign b_rdata  = pend_rd[1] ? ram_out : '0;

endmodule

// File: tb/tb_ram512_arbiter.sv
// Directed bench for ram512_arbiter: vector table for single-cycle behaviour plus
// hand-written sequences for burst limit, lock release and reset during a read.
module tb_ram512_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_req, a_we, a_lock;
    logic [8:0]  a_addr;
    logic [15:0] a_wdata;
    logic        a_gnt, a_rvalid;
    logic [15:0] a_rdata;
    logic        b_req, b_we, b_lock;
    logic [8:0]  b_addr;
    logic [15:0] b_wdata;
    logic        b_gnt, b_rvalid;
    logic [15:0] b_rdata;
    logic [15:0] ram_data;
    logic        ram_load;
    logic [8:0]  ram_address;
    logic [15:0] ram_out;

    int checks = 0;
    int errors = 0;

    ram512_arbiter #(.ADDR_W(9), .DATA_W(16), .MAX_BURST(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_data(ram_data), .ram_load(ram_load), .ram_address(ram_address), .ram_out(ram_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered read, word i preloaded with value i.
    logic [15:0] mem [512];
    initial for (int i = 0; i < 512; i++) mem[i] = 16'(i);
    always @(posedge clk) begin
        if (ram_load) mem[ram_address] <= ram_data;
        ram_out <= mem[ram_address];
    end

    typedef struct {
        logic        a_req, a_we, a_lock;
        logic [8:0]  a_addr;
        logic [15:0] a_wdata;
        logic        b_req, b_we, b_lock;
        logic [8:0]  b_addr;
        logic [15:0] b_wdata;
        logic        e_agnt, e_bgnt, e_load;
        logic [8:0]  e_addr;
        logic [15:0] e_data;
        logic        e_arv;
        logic [15:0] e_ard;
        logic        e_brv;
        logic [15:0] e_brd;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_a(input logic req, input logic we, input logic lock,
                         input logic [8:0] addr, input logic [15:0] wdata);
        a_req = req; a_we = we; a_lock = lock; a_addr = addr; a_wdata = wdata;
    endtask

    task automatic set_b(input logic req, input logic we, input logic lock,
                         input logic [8:0] addr, input logic [15:0] wdata);
        b_req = req; b_we = we; b_lock = lock; b_addr = addr; b_wdata = wdata;
    endtask

    task automatic idle();
        set_a(1'b0, 1'b0, 1'b0, 9'h000, 16'h0000);
        set_b(1'b0, 1'b0, 1'b0, 9'h000, 16'h0000);
    endtask

    // Entered and left just after a rising edge.
    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1,1'b0,1'b0,9'h003,16'h0000, 1'b1,1'b0,1'b0,9'h004,16'h0000,
                     1'b1,1'b0,1'b0,9'h003,16'h0000, 1'b0,16'h0000,1'b0,16'h0000};
        vecs[1]  = '{1'b1,1'b0,1'b0,9'h003,16'h0000, 1'b1,1'b0,1'b0,9'h004,16'h0000,
                     1'b0,1'b1,1'b0,9'h004,16'h0000, 1'b1,16'h0003,1'b0,16'h0000};
        vecs[2]  = '{1'b1,1'b0,1'b0,9'h003,16'h0000, 1'b1,1'b0,1'b0,9'h004,16'h0000,
                     1'b1,1'b0,1'b0,9'h003,16'h0000, 1'b0,16'h0000,1'b1,16'h0004};
        vecs[3]  = '{1'b1,1'b0,1'b0,9'h003,16'h0000, 1'b1,1'b0,1'b0,9'h004,16'h0000,
                     1'b0,1'b1,1'b0,9'h004,16'h0000, 1'b1,16'h0003,1'b0,16'h0000};
        vecs[4]  = '{1'b1,1'b1,1'b0,9'h1A5,16'hBEEF, 1'b0,1'b0,1'b0,9'h000,16'h0000,
                     1'b1,1'b0,1'b1,9'h1A5,16'hBEEF, 1'b0,16'h0000,1'b1,16'h0004};
        vecs[5]  = '{1'b1,1'b0,1'b0,9'h1A5,16'h0000, 1'b0,1'b0,1'b0,9'h000,16'h0000,
                     1'b1,1'b0,1'b0,9'h1A5,16'h0000, 1'b0,16'h0000,1'b0,16'h0000};
        vecs[6]  = '{1'b0,1'b0,1'b0,9'h000,16'h0000, 1'b0,1'b0,1'b0,9'h000,16'h0000,
                     1'b0,1'b0,1'b0,9'h000,16'h0000, 1'b1,16'hBEEF,1'b0,16'h0000};
        vecs[7]  = '{1'b0,1'b0,1'b0,9'h000,16'h0000, 1'b0,1'b0,1'b0,9'h000,16'h0000,
                     1'b0,1'b0,1'b0,9'h000,16'h0000, 1'b0,16'h0000,1'b0,16'h0000};
        vecs[8]  = '{1'b0,1'b0,1'b0,9'h000,16'h0000, 1'b1,1'b1,1'b0,9'h010,16'h1234,
                     1'b0,1'b1,1'b1,9'h010,16'h1234, 1'b0,16'h0000,1'b0,16'h0000};
        vecs[9]  = '{1'b0,1'b0,1'b0,9'h000,16'h0000, 1'b1,1'b0,1'b0,9'h010,16'h0000,
                     1'b0,1'b1,1'b0,9'h010,16'h0000, 1'b0,16'h0000,1'b0,16'h0000};
        vecs[10] = '{1'b1,1'b0,1'b0,9'h1FF,16'h0000, 1'b0,1'b0,1'b0,9'h000,16'h0000,
                     1'b1,1'b0,1'b0,9'h1FF,16'h0000, 1'b0,16'h0000,1'b1,16'h1234};
        vecs[11] = '{1'b0,1'b0,1'b0,9'h000,16'h0000, 1'b0,1'b0,1'b0,9'h000,16'h0000,
                     1'b0,1'b0,1'b0,9'h000,16'h0000, 1'b1,16'h01FF,1'b0,16'h0000};

        // Reset held with both sides requesting: everything quiet.
        rst_n = 1'b0;
        set_a(1'b1, 1'b1, 1'b1, 9'h1A5, 16'hBEEF);
        set_b(1'b1, 1'b0, 1'b0, 9'h0AA, 16'h5555);
        #12;
        check("rst a_gnt", 32'(a_gnt), 32'd0);
        check("rst b_gnt", 32'(b_gnt), 32'd0);
        check("rst ram_load", 32'(ram_load), 32'd0);
        check("rst ram_address", 32'(ram_address), 32'd0);
        check("rst ram_data", 32'(ram_data), 32'd0);
        check("rst a_rvalid", 32'(a_rvalid), 32'd0);
        check("rst b_rvalid", 32'(b_rvalid), 32'd0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table: round-robin reads, A write/read, B write/read, top address.
        for (int i = 0; i < 12; i++) begin
            set_a(vecs[i].a_req, vecs[i].a_we, vecs[i].a_lock, vecs[i].a_addr, vecs[i].a_wdata);
            set_b(vecs[i].b_req, vecs[i].b_we, vecs[i].b_lock, vecs[i].b_addr, vecs[i].b_wdata);
            @(negedge clk);
            check($sformatf("v%0d a_gnt", i), 32'(a_gnt), 32'(vecs[i].e_agnt));
            check($sformatf("v%0d b_gnt", i), 32'(b_gnt), 32'(vecs[i].e_bgnt));
            check($sformatf("v%0d ram_load", i), 32'(ram_load), 32'(vecs[i].e_load));
            check($sformatf("v%0d ram_address", i), 32'(ram_address), 32'(vecs[i].e_addr));
            check($sformatf("v%0d ram_data", i), 32'(ram_data), 32'(vecs[i].e_data));
            check($sformatf("v%0d a_rvalid", i), 32'(a_rvalid), 32'(vecs[i].e_arv));
            check($sformatf("v%0d a_rdata", i), 32'(a_rdata), 32'(vecs[i].e_ard));
            check($sformatf("v%0d b_rvalid", i), 32'(b_rvalid), 32'(vecs[i].e_brv));
            check($sformatf("v%0d b_rdata", i), 32'(b_rdata), 32'(vecs[i].e_brd));
            @(posedge clk); #1;
        end

        // Burst limit with B requesting: A x8, B x1, repeating.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_a(1'b1, 1'b0, 1'b1, 9'h003, 16'h0000);
            set_b(1'b1, 1'b0, 1'b0, 9'h004, 16'h0000);
            @(negedge clk);
            check($sformatf("burst%0d a_gnt", i), 32'(a_gnt), ((i % 9) == 8) ? 32'd0 : 32'd1);
            check($sformatf("burst%0d b_gnt", i), 32'(b_gnt), ((i % 9) == 8) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end

        // B idle: a locked A is granted every cycle, past counter saturation.
        set_b(1'b0, 1'b0, 1'b0, 9'h000, 16'h0000);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("solo%0d a_gnt", i), 32'(a_gnt), 32'd1);
            @(posedge clk); #1;
        end
        // Counter is saturated well beyond the limit, so B wins immediately.
        set_b(1'b1, 1'b0, 1'b0, 9'h004, 16'h0000);
        @(negedge clk);
        check("sat b_gnt", 32'(b_gnt), 32'd1);
        check("sat a_gnt", 32'(a_gnt), 32'd0);
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        check("idle a_gnt", 32'(a_gnt), 32'd0);
        check("idle b_gnt", 32'(b_gnt), 32'd0);
        @(posedge clk); #1;

        // Lock release: three locked grants, then lock dropped while B requests.
        for (int i = 0; i < 3; i++) begin
            set_a(1'b1, 1'b0, 1'b1, 9'h003, 16'h0000);
            @(negedge clk);
            check($sformatf("lock%0d a_gnt", i), 32'(a_gnt), 32'd1);
            @(posedge clk); #1;
        end
        set_a(1'b1, 1'b0, 1'b0, 9'h003, 16'h0000);
        set_b(1'b1, 1'b0, 1'b0, 9'h004, 16'h0000);
        @(negedge clk);
        check("unlock hold a_gnt", 32'(a_gnt), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("unlock b_gnt", 32'(b_gnt), 32'd1);
        check("unlock a_gnt", 32'(a_gnt), 32'd0);
        @(posedge clk); #1;
        // Dropping req ends ownership at once.
        set_a(1'b1, 1'b0, 1'b1, 9'h003, 16'h0000);
        set_b(1'b0, 1'b0, 1'b0, 9'h000, 16'h0000);
        @(negedge clk);
        check("reqdrop lock a_gnt", 32'(a_gnt), 32'd1);
        @(posedge clk); #1;
        set_a(1'b0, 1'b0, 1'b0, 9'h000, 16'h0000);
        set_b(1'b1, 1'b0, 1'b0, 9'h004, 16'h0000);
        @(negedge clk);
        check("reqdrop b_gnt", 32'(b_gnt), 32'd1);
        @(posedge clk); #1;

        // Reset asserted the cycle after a granted B read.
        set_b(1'b1, 1'b0, 1'b0, 9'h004, 16'h0000);
        @(negedge clk);
        check("midrst b_gnt", 32'(b_gnt), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        set_b(1'b0, 1'b0, 1'b0, 9'h000, 16'h0000);
        set_a(1'b1, 1'b1, 1'b0, 9'h1A5, 16'h7777);
        #1;
        check("midrst b_rvalid", 32'(b_rvalid), 32'd0);
        check("midrst b_rdata", 32'(b_rdata), 32'd0);
        check("midrst a_gnt", 32'(a_gnt), 32'd0);
        check("midrst ram_address", 32'(ram_address), 32'd0);
        check("midrst ram_load", 32'(ram_load), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("midrst hold%0d b_rvalid", i), 32'(b_rvalid), 32'd0);
        end
        idle();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check($sformatf("postrst%0d b_rvalid", i), 32'(b_rvalid), 32'd0);
            check($sformatf("postrst%0d a_rvalid", i), 32'(a_rvalid), 32'd0);
        end
        @(posedge clk); #1;

        // Pointer returns to A-first even if A won last before reset.
        set_a(1'b1, 1'b0, 1'b0, 9'h003, 16'h0000);
        @(negedge clk);
        check("ptr pre a_gnt", 32'(a_gnt), 32'd1);
        @(posedge clk); #1;
        do_reset();
        set_a(1'b1, 1'b0, 1'b0, 9'h003, 16'h0000);
        set_b(1'b1, 1'b0, 1'b0, 9'h004, 16'h0000);
        @(negedge clk);
        check("ptr a_gnt", 32'(a_gnt), 32'd1);
        check("ptr b_gnt", 32'(b_gnt), 32'd0);
        @(posedge clk); #1;
        idle();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram512_arbiter.md
Name: ram512_arbiter

Overview:
- Two-requester arbiter sharing the single-port 512x16 data RAM: requester A (CPU data port) and requester B (screen-refresh/DMA engine).
- Drives the RAM's data, load and address inputs and routes its registered read output back to the requester that issued the read.
- Round-robin arbitration with a bounded lock (burst) mechanism.
- Sits between the CPU/DMA blocks and the RAM instance.

Parameters:
- ADDR_W, 9, RAM address width (512 words).
- DATA_W, 16, word width.
- MAX_BURST, 8, maximum consecutive locked grants for one owner while the other requests (range 1..15).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a_req  input  1  A requests an access this cycle.
- a_we  input  1  A access is a write (1) or read (0).
- a_lock  input  1  A asks to keep ownership next cycle.
- a_addr  input  ADDR_W  A word address.
- a_wdata  input  DATA_W  A write data.
- a_gnt  output  1  A access accepted at this clock edge.
- a_rvalid  output  1  a_rdata holds A's read result.
- a_rdata  output  DATA_W  A read data.
- b_req, b_we, b_lock, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for B.
- ram_data  output  DATA_W  to RAM data.
- ram_load  output  1  to RAM load.
- ram_address  output  ADDR_W  to RAM address.
- ram_out  input  DATA_W  from RAM out (registered, valid the cycle after the address is presented).

Behaviour:
- Reset (rst_n low, asynchronous) clears all state:
  - owner = NONE, last = B (A wins the first tie), burst_cnt = 0, pending-read tag = none.
  - Outputs forced while rst_n is low: a_gnt = b_gnt = 0, ram_load = 0, ram_address = 0, ram_data = 0, rvalid = 0, rdata = 0.
- States are owner ∈ {NONE, A, B}. Counter burst_cnt is 4 bits and counts consecutive granted cycles of the current owner.
- Grant decision is combinational each cycle and evaluated in this order:
  1. Lock hold: if owner = X, x_req = 1, x_lock was 1 on the previous grant, and (burst_cnt < MAX_BURST or the other requester is idle), then grant X.
  2. Otherwise, if exactly one requester has req = 1, grant it.
  3. Otherwise, if both request, grant the requester that is not `last`.
  4. Otherwise, grant none.
- Exactly one of a_gnt/b_gnt is high when any req is high; neither is high otherwise. gnt never asserts without the matching req.
- Granted requester's inputs drive the RAM in the same cycle:
  - ram_address = x_addr.
  - ram_data = x_wdata.
  - ram_load = x_we.
- With no grant: ram_load = 0, ram_address = 0, ram_data = 0.
- At each clock edge:
  - On grant to X:
    - last ← X.
    - If owner = X, burst_cnt ← min(burst_cnt + 1, 15); otherwise burst_cnt ← 1.
    - owner ← X if x_lock = 1, else NONE.
  - With no grant: owner ← NONE, burst_cnt ← 0.
- Requester handshake: hold req/we/addr/wdata stable until gnt is seen. The transfer completes at the edge where req & gnt = 1. The requester may change inputs the following cycle.
- Read latency is 1 cycle. A read granted in cycle N gives x_rvalid = 1 and x_rdata = ram_out in cycle N+1.
  - Pending tag is a 2-bit register: bit per requester, set on a granted read.
  - x_rdata = 0 whenever x_rvalid = 0.
  - Back-to-back reads (including alternating A/B) are fully pipelined: one result per cycle.
- Writes produce no rvalid. A write followed by a read of the same address in the next cycle returns the new data; the RAM handles this.
- Write and read in the same cycle from different requesters is impossible, because only one grant is issued per cycle.
- Lock release: dropping x_lock or x_req ends ownership at the next decision.
- Burst limit: with MAX_BURST = 8 and the other side requesting, a locked owner gets at most 8 consecutive grants. Grant then passes to the other side for at least one cycle.
- Reset asserted mid-operation: any in-flight read is discarded (no rvalid after reset release), and the pointer returns to A-first.

Test Plan:
- Reset/idle: hold rst_n = 0 with a_req = b_req = 1. Require a_gnt = b_gnt = ram_load = 0 and ram_address = 0. After release, the first cycle with both requesting grants A.
- Single write/read: A writes 0xBEEF to addr 0x1A5, then reads 0x1A5. Require ram_load = 1 in the write cycle, a_gnt on both cycles, and a_rvalid = 1 with a_rdata = 0xBEEF exactly one cycle after the read grant. b_rvalid stays 0.
- Round-robin: A and B both issue continuous reads, A of addr 3 (value 0x0003), B of addr 4 (value 0x0004). Require grants alternate A,B,A,B and rvalid alternates with matching data 0x0003/0x0004.
- Burst limit: A holds req + lock for 20 cycles while B requests continuously. Require A granted 8 cycles, then B 1 cycle, then A 8 again. With B idle, A is granted all 20 cycles.
- Lock release: A locks for 3 grants then drops lock while B requests. Require B granted in the next cycle.
- Reset mid-read: assert rst_n = 0 in the cycle after a granted B read. Require b_rvalid = 0 throughout and after release, with no spurious rvalid.
